// File: rtl/signed_bcd_converter_module_if.sv
// Start/Done handshake bus between the display controller and the BCD converter.
// The controller drives the master side and the converter drives the slave side.
interface signed_bcd_converter_module_if;
    logic       Start_Sig;
    logic [7:0] Value;
    logic       Done_Sig;
    logic       Sign;
    logic [3:0] Hundreds;
    logic [3:0] Tens;
    logic [3:0] Ones;

    modport master (
        output Start_Sig, Value,
        input  Done_Sig, Sign, Hundreds, Tens, Ones
    );

    modport slave (
        input  Start_Sig, Value,
        output Done_Sig, Sign, Hundreds, Tens, Ones
    );
endinterface

// File: rtl/signed_bcd_converter_module.sv
// Converts an 8-bit divider result into a sign plus three BCD digits using double dabble.
// One bit is shifted per clock, and the FSM only advances while Start_Sig is held high.
module signed_bcd_converter_module #(
    parameter int SIGNED = 1
) (
    input  logic                                 CLK,
    input  logic                                 RSTn,
    signed_bcd_converter_module_if.slave         bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] CLEAR = 2'd3;

    localparam logic IS_SIGNED = (SIGNED != 0);

    logic [1:0]  state_q,    state_d;
    logic [2:0]  count_q,    count_d;
    logic [7:0]  mag_q,      mag_d;
    logic [11:0] bcd_q,      bcd_d;
    logic        neg_q,      neg_d;
    logic        done_q,     done_d;
    logic        sign_q,     sign_d;
    logic [3:0]  hundreds_q, hundreds_d;
    logic [3:0]  tens_q,     tens_d;
    logic [3:0]  ones_q,     ones_d;
    logic [11:0] bcdAdj;

    always_comb begin
        bcdAdj[3:0]  = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
        bcdAdj[7:4]  = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
        bcdAdj[11:8] = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
    end

    // Dropping Start_Sig freezes every state, so a paused conversion resumes where it stopped.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        done_d     = done_q;
        sign_d     = sign_q;
        hundreds_d = hundreds_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        if (bus.Start_Sig) begin
            case (state_q)
                IDLE: begin
                    mag_d   = (IS_SIGNED && bus.Value[7]) ? (~bus.Value + 8'd1) : bus.Value;
                    neg_d   = IS_SIGNED & bus.Value[7];
                    bcd_d   = 12'd0;
                    count_d = 3'd0;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    {bcd_d, mag_d} = {bcdAdj, mag_q} << 1;
                    count_d        = count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    hundreds_d = bcd_q[11:8];
                    tens_d     = bcd_q[7:4];
                    ones_d     = bcd_q[3:0];
                    sign_d     = neg_q;
                    done_d     = 1'b1;
                    state_d    = CLEAR;
                end
                CLEAR: begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            count_q    <= 3'd0;
            mag_q      <= 8'd0;
            bcd_q      <= 12'd0;
            neg_q      <= 1'b0;
            done_q     <= 1'b0;
            sign_q     <= 1'b0;
            hundreds_q <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            done_q     <= done_d;
            sign_q     <= sign_d;
            hundreds_q <= hundreds_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
        end
    end

    assign bus.Done_Sig = done_q;
    assign bus.Sign     = sign_q;
    assign bus.Hundreds = hundreds_q;
    assign bus.Tens     = tens_q;
    assign bus.Ones     = ones_q;

endmodule

// File: tb/tb_signed_bcd_converter_module.sv
// Directed bench for the signed BCD converter, covering both the signed and unsigned builds.
// Expected digits are hand-computed, and the controller is modelled as dropping Start one edge after Done.
module tb_signed_bcd_converter_module;

    logic CLK;
    logic RSTn;
    int   errors;
    int   checks;

    signed_bcd_converter_module_if busS ();
    signed_bcd_converter_module_if busU ();

    signed_bcd_converter_module #(.SIGNED(1)) dutS (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (busS)
    );

    signed_bcd_converter_module #(.SIGNED(0)) dutU (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (busU)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Results are packed as {3'b0, Sign, Hundreds, Tens, Ones} so that one comparison covers the whole display.
    function automatic logic [15:0] expRes(input logic s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        return {3'b000, s, h, t, o};
    endfunction

    function automatic logic [15:0] result(input bit u);
        if (u) return {3'b000, busU.Sign, busU.Hundreds, busU.Tens, busU.Ones};
        return {3'b000, busS.Sign, busS.Hundreds, busS.Tens, busS.Ones};
    endfunction

    function automatic logic done(input bit u);
        return u ? busU.Done_Sig : busS.Done_Sig;
    endfunction

    function automatic logic rangeOk(input bit u);
        logic [15:0] r;
        r = result(u);
        return (r[11:8] <= 4'd2) && (r[7:4] <= 4'd9) && (r[3:0] <= 4'd9);
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit u, input logic start, input logic [7:0] val);
        if (u) begin
            busU.Start_Sig = start;
            busU.Value     = val;
        end else begin
            busS.Start_Sig = start;
            busS.Value     = val;
        end
    endtask

    // Waits at most 40 edges; if the budget runs out, the latency comparison that follows fails.
    task automatic waitDone(input bit u, output int n);
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!done(u) && n < 40);
    endtask

    task automatic convert(input string tag, input bit u, input logic [7:0] val, input logic [15:0] expected);
        int n;
        applyStimulus(u, 1'b1, val);
        waitDone(u, n);
        checkOutput({tag, "_latency"}, 16'(n), 16'd10);
        checkOutput({tag, "_result"}, result(u), expected);
        checkOutput({tag, "_range"}, {15'd0, rangeOk(u)}, 16'd1);
        @(posedge CLK);
        #1;
        applyStimulus(u, 1'b0, val);
        checkOutput({tag, "_donefall"}, {15'd0, done(u)}, 16'd0);
        @(posedge CLK);
        #1;
        checkOutput({tag, "_norerun"}, {15'd0, done(u)}, 16'd0);
        checkOutput({tag, "_hold"}, result(u), expected);
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        RSTn   = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        #12;
        checkOutput("reset_s", {done(1'b0), result(1'b0)}, 16'd0);
        checkOutput("reset_u", {done(1'b1), result(1'b1)}, 16'd0);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        convert("s_7B", 1'b0, 8'h7B, expRes(1'b0, 4'd1, 4'd2, 4'd3));
        convert("s_F6", 1'b0, 8'hF6, expRes(1'b1, 4'd0, 4'd1, 4'd0));
        convert("s_80", 1'b0, 8'h80, expRes(1'b1, 4'd1, 4'd2, 4'd8));
        convert("s_FF", 1'b0, 8'hFF, expRes(1'b1, 4'd0, 4'd0, 4'd1));
        convert("s_00", 1'b0, 8'h00, expRes(1'b0, 4'd0, 4'd0, 4'd0));
        convert("u_FF", 1'b1, 8'hFF, expRes(1'b0, 4'd2, 4'd5, 4'd5));
        convert("u_00", 1'b1, 8'h00, expRes(1'b0, 4'd0, 4'd0, 4'd0));

        // Pause after the fourth shift; the Value written during the gap must be ignored.
        applyStimulus(1'b0, 1'b1, 8'h85);
        repeat (5) begin
            @(posedge CLK);
            #1;
        end
        checkOutput("gap_nodone", {15'd0, done(1'b0)}, 16'd0);
        applyStimulus(1'b0, 1'b0, 8'h11);
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        checkOutput("gap_frozen_done", {15'd0, done(1'b0)}, 16'd0);
        checkOutput("gap_frozen_hold", result(1'b0), expRes(1'b0, 4'd0, 4'd0, 4'd0));
        applyStimulus(1'b0, 1'b1, 8'h11);
        waitDone(1'b0, n);
        checkOutput("gap_latency", 16'(n), 16'd5);
        checkOutput("gap_result", result(1'b0), expRes(1'b1, 4'd1, 4'd2, 4'd3));
        @(posedge CLK);
        #1;
        applyStimulus(1'b0, 1'b0, 8'h11);
        checkOutput("gap_donefall", {15'd0, done(1'b0)}, 16'd0);
        @(posedge CLK);
        #1;

        // Asynchronous reset in the middle of SHIFT clears the outputs without waiting for an edge.
        applyStimulus(1'b0, 1'b1, 8'h7B);
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        RSTn = 1'b0;
        #1;
        checkOutput("rst_mid_s", {done(1'b0), result(1'b0)}, 16'd0);
        checkOutput("rst_mid_u", {done(1'b1), result(1'b1)}, 16'd0);
        applyStimulus(1'b0, 1'b0, 8'h7B);
        #2;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        convert("post_rst_2A", 1'b0, 8'h2A, expRes(1'b0, 4'd0, 4'd4, 4'd2));

        // Holding Start across Done reruns the conversion back to back, every 11 cycles.
        applyStimulus(1'b0, 1'b1, 8'h09);
        waitDone(1'b0, n);
        checkOutput("b2b_first_latency", 16'(n), 16'd10);
        checkOutput("b2b_first_result", result(1'b0), expRes(1'b0, 4'd0, 4'd0, 4'd9));
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(posedge CLK);
                #1;
                n++;
                if (n == 5) checkOutput("b2b_between", result(1'b0), expRes(1'b0, 4'd0, 4'd0, 4'd9));
            end while (!done(1'b0) && n < 40);
            checkOutput("b2b_period", 16'(n), 16'd11);
            checkOutput("b2b_result", result(1'b0), expRes(1'b0, 4'd0, 4'd0, 4'd9));
        end
        @(posedge CLK);
        #1;
        applyStimulus(1'b0, 1'b0, 8'h09);
        checkOutput("b2b_donefall", {15'd0, done(1'b0)}, 16'd0);
        repeat (2) @(posedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
